// File: rtl/dense_feeder.sv
// dense_feeder
// Feeds one dense-neuron job to a denseAccelerator. It sends a header beat
// carrying N, then fetches act[0], wt[0], ..., act[N-1], wt[N-1], bias from
// word memory, forwards every read word as a beat two cycles after its read,
// and captures the accelerator's sum once the bias beat has gone out.
//
// Ports
//   clk, reset          clock, asynchronous active-low reset
//   start, length       job request and pair count N (sampled in IDLE only)
//   act_base, wt_base   word addresses of activation 0 / weight 0
//   bias_addr           word address of the bias
//   pause               holds off new memory reads while high
//   mem_rd, mem_addr    read strobe / word address
//   mem_rdata           read data, valid the cycle after mem_rd
//   acc_valid, acc_data beat strobe / beat data to the accelerator
//   acc_length          N of the most recently accepted job
//   acc_result          accelerator sum
//   busy, done, result  job in progress, completion pulse, captured sum
//
// state   | meaning
// IDLE    | waiting for start; a zero-length start completes here directly
// HDR     | header beat queued; read act[0] may issue in the same cycle
// STREAM  | issuing the remaining reads, gated by pause
// WAIT    | all reads issued; draining the beat pipeline to the bias beat
// CAPTURE | bias beat has gone out; sample acc_result, pulse done next cycle
module dense_feeder (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] length,
    input  logic [15:0] act_base,
    input  logic [15:0] wt_base,
    input  logic [15:0] bias_addr,
    input  logic        pause,
    output logic        mem_rd,
    output logic [15:0] mem_addr,
    input  logic [31:0] mem_rdata,
    output logic        acc_valid,
    output logic [31:0] acc_data,
    output logic [31:0] acc_length,
    input  logic [31:0] acc_result,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);
    typedef enum logic [2:0] {IDLE, HDR, STREAM, WAIT, CAPTURE} state_t;

    state_t      state_q, state_d;
    logic [31:0] len_q, len_d;
    logic [15:0] act_base_q, act_base_d;
    logic [15:0] wt_base_q, wt_base_d;
    logic [15:0] bias_q, bias_d;
    logic [31:0] rd_cnt_q, rd_cnt_d;
    logic [31:0] beat_cnt_q, beat_cnt_d;
    logic        pend_q;
    logic        acc_valid_q, acc_valid_d;
    logic [31:0] acc_data_q, acc_data_d;
    logic        done_q, done_d;
    logic [31:0] result_q, result_d;

    logic [31:0] total_rd;
    logic [31:0] last_rd;
    logic [15:0] pair_idx;
    logic [15:0] rd_addr;
    logic        rd_en;

    // 2N+1 fits in 32 bits for any N below 2^31.
    always_comb begin
        total_rd = {len_q[30:0], 1'b1};
        last_rd  = {len_q[30:0], 1'b0};
        pair_idx = rd_cnt_q[16:1];
        if (rd_cnt_q == last_rd) begin
            rd_addr = bias_q;
        end else if (rd_cnt_q[0]) begin
            rd_addr = wt_base_q + pair_idx;
        end else begin
            rd_addr = act_base_q + pair_idx;
        end
        // The first read goes out alongside the header so the header beat and
        // the data beats form one unbroken run when nothing pauses.
        rd_en = ((state_q == HDR) || (state_q == STREAM)) &&
                (rd_cnt_q != total_rd) && !pause;
    end

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        act_base_d  = act_base_q;
        wt_base_d   = wt_base_q;
        bias_d      = bias_q;
        rd_cnt_d    = rd_cnt_q + 32'(rd_en);
        beat_cnt_d  = beat_cnt_q + 32'(pend_q);
        acc_valid_d = pend_q;
        acc_data_d  = pend_q ? mem_rdata : 32'h0;
        done_d      = 1'b0;
        result_d    = result_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (length != 32'h0) begin
                        len_d      = length;
                        act_base_d = act_base;
                        wt_base_d  = wt_base;
                        bias_d     = bias_addr;
                        rd_cnt_d   = 32'h0;
                        beat_cnt_d = 32'h0;
                        state_d    = HDR;
                    end else begin
                        done_d   = 1'b1;
                        result_d = 32'h0;
                    end
                end
            end
            HDR: begin
                acc_valid_d = 1'b1;
                acc_data_d  = len_q;
                state_d     = STREAM;
            end
            STREAM: begin
                if (rd_en && (rd_cnt_q == last_rd)) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // Every read has entered the beat register, so the beat on
                // the output right now is the bias beat.
                if (beat_cnt_q == total_rd) begin
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                result_d = acc_result;
                done_d   = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            len_q       <= 32'h0;
            act_base_q  <= 16'h0;
            wt_base_q   <= 16'h0;
            bias_q      <= 16'h0;
            rd_cnt_q    <= 32'h0;
            beat_cnt_q  <= 32'h0;
            pend_q      <= 1'b0;
            acc_valid_q <= 1'b0;
            acc_data_q  <= 32'h0;
            done_q      <= 1'b0;
            result_q    <= 32'h0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            act_base_q  <= act_base_d;
            wt_base_q   <= wt_base_d;
            bias_q      <= bias_d;
            rd_cnt_q    <= rd_cnt_d;
            beat_cnt_q  <= beat_cnt_d;
            pend_q      <= rd_en;
            acc_valid_q <= acc_valid_d;
            acc_data_q  <= acc_data_d;
            done_q      <= done_d;
            result_q    <= result_d;
        end
    end

    assign mem_rd     = rd_en;
    assign mem_addr   = rd_en ? rd_addr : 16'h0;
    assign acc_valid  = acc_valid_q;
    assign acc_data   = acc_data_q;
    assign acc_length = len_q;
    assign busy       = (state_q != IDLE);
    assign done       = done_q;
    assign result     = result_q;
endmodule

// File: tb/tb_dense_feeder.sv
// Bench for dense_feeder: word memory with one-cycle read latency, a small
// Q8.24 denseAccelerator stand-in, a directed job table, random jobs with
// random pause, and a hand-written mid-job reset sequence.
module tb_dense_feeder;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        pause = 1'b0;
    logic [31:0] length = 32'h0;
    logic [15:0] act_base = 16'h0;
    logic [15:0] wt_base = 16'h0;
    logic [15:0] bias_addr = 16'h0;
    logic        mem_rd;
    logic [15:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        acc_valid;
    logic [31:0] acc_data;
    logic [31:0] acc_length;
    logic [31:0] acc_result;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int checks = 0;
    int failures = 0;
    int cur_c = 0;

    always #5 clk = ~clk;

    dense_feeder dut (
        .clk(clk), .reset(reset), .start(start), .length(length),
        .act_base(act_base), .wt_base(wt_base), .bias_addr(bias_addr),
        .pause(pause), .mem_rd(mem_rd), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .acc_valid(acc_valid), .acc_data(acc_data),
        .acc_length(acc_length), .acc_result(acc_result), .busy(busy),
        .done(done), .result(result)
    );

    logic [31:0] mem [0:65535];
    always @(posedge clk) mem_rdata <= mem_rd ? mem[mem_addr] : 32'hDEADBEEF;

    function automatic logic [31:0] fx(input logic [31:0] a, input logic [31:0] w);
        logic signed [63:0] p;
        p = $signed({{32{a[31]}}, a}) * $signed({{32{w[31]}}, w});
        return p[55:24];
    endfunction

    // Accelerator stand-in: header, N act/wt pairs, bias; sum appears the
    // cycle after the bias beat.
    int unsigned st_cnt;
    logic [31:0] st_len, st_sum, st_act;
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            st_cnt <= 0; st_len <= 0; st_sum <= 0; st_act <= 0; acc_result <= 0;
        end else if (acc_valid) begin
            if (st_cnt == 0) begin
                st_len <= acc_data; st_sum <= 0; st_cnt <= 1;
            end else if (st_cnt == 2 * st_len + 1) begin
                acc_result <= st_sum + acc_data; st_cnt <= 0;
            end else if (st_cnt % 2 == 1) begin
                st_act <= acc_data; st_cnt <= st_cnt + 1;
            end else begin
                st_sum <= st_sum + fx(st_act, acc_data); st_cnt <= st_cnt + 1;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", nm, cur_c, got, exp);
        end
    endtask

    typedef struct packed {
        logic [31:0]       n;
        logic [15:0]       ab;
        logic [15:0]       wb;
        logic [15:0]       ba;
        logic [7:0][31:0]  act;
        logic [7:0][31:0]  wt;
        logic [31:0]       bias;
        int                p_at;
        int                p_len;
        bit                rnd_pause;
        bit                spam;
        bit                chain;
        bit                directed;
        logic [31:0]       exp_res;
        int                exp_done;
    } job_t;

    // Runs one job. cycle 0 is the cycle start is driven; expected reads,
    // beats and done cycle come from walking the pause pattern.
    task automatic run_job(input job_t j, input bit chained);
        bit          pat    [0:255];
        bit          e_rd   [0:255];
        logic [15:0] e_addr [0:255];
        bit          e_v    [0:255];
        logic [31:0] e_d    [0:255];
        logic [15:0] addrs  [$];
        logic [31:0] e_res;
        int          k, d, lastc;
        for (int i = 0; i < int'(j.n); i++) begin
            mem[j.ab + 16'(i)] = j.act[i];
            mem[j.wb + 16'(i)] = j.wt[i];
        end
        if (j.n != 0) mem[j.ba] = j.bias;
        for (int i = 0; i < int'(j.n); i++) begin
            addrs.push_back(j.ab + 16'(i));
            addrs.push_back(j.wb + 16'(i));
        end
        if (j.n != 0) addrs.push_back(j.ba);
        e_res = 0;
        for (int i = 0; i < int'(j.n); i++) e_res += fx(mem[addrs[2*i]], mem[addrs[2*i+1]]);
        if (j.n != 0) e_res += mem[j.ba];
        for (int c = 0; c < 256; c++) begin
            if (j.rnd_pause) pat[c] = (c < 40) && ($urandom_range(0, 3) == 0);
            else             pat[c] = (c >= j.p_at) && (c < j.p_at + j.p_len);
            e_rd[c] = 0; e_addr[c] = 0; e_v[c] = 0; e_d[c] = 0;
        end
        k = 0; lastc = 0;
        if (j.n != 0) begin
            e_v[2] = 1; e_d[2] = j.n;
            for (int c = 1; c < 250 && k < addrs.size(); c++) begin
                if (!pat[c]) begin
                    e_rd[c] = 1; e_addr[c] = addrs[k];
                    e_v[c+2] = 1; e_d[c+2] = mem[addrs[k]];
                    k++; lastc = c;
                end
            end
            d = lastc + 4;
        end else begin
            d = 1;
        end
        if (j.directed) begin
            d = j.exp_done; e_res = j.exp_res;
        end
        if (!chained) begin
            repeat (2) @(posedge clk);
            #1;
        end
        length = j.n; act_base = j.ab; wt_base = j.wb; bias_addr = j.ba;
        pause = 0; start = 1;
        for (int c = 1; c <= d; c++) begin
            @(posedge clk); #1;
            start = j.spam && c >= 3 && c <= 5;
            pause = pat[c];
            #1; cur_c = c;
            chk("mem_rd", 32'(mem_rd), 32'(e_rd[c]));
            if (e_rd[c]) chk("mem_addr", 32'(mem_addr), 32'(e_addr[c]));
            chk("acc_valid", 32'(acc_valid), 32'(e_v[c]));
            if (e_v[c]) chk("acc_data", acc_data, e_d[c]);
            chk("done", 32'(done), 32'(c == d));
            chk("busy", 32'(busy), 32'(c != d));
            if (j.n != 0) chk("acc_length", acc_length, j.n);
        end
        chk("result", result, e_res);
        pause = 0;
    endtask

    job_t tbl [5];
    job_t rj;
    bit   prev_chain;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 32'h0;
        for (int i = 0; i < 5; i++) tbl[i] = '0;
        // two-pair reference job; a busy start is spammed and the next job
        // starts in its done cycle
        tbl[0].n = 2; tbl[0].ab = 16'h0100; tbl[0].wb = 16'h0200; tbl[0].ba = 16'h0300;
        tbl[0].act[0] = 32'h01000000; tbl[0].act[1] = 32'h02000000;
        tbl[0].wt[0]  = 32'h00800000; tbl[0].wt[1]  = 32'h01000000;
        tbl[0].bias = 32'h00100000; tbl[0].p_at = 999;
        tbl[0].spam = 1; tbl[0].chain = 1; tbl[0].directed = 1;
        tbl[0].exp_res = 32'h02900000; tbl[0].exp_done = 9;
        // address wrap
        tbl[1].n = 2; tbl[1].ab = 16'hFFFF; tbl[1].wb = 16'h8000; tbl[1].ba = 16'h1234;
        tbl[1].act[0] = 32'h00100000; tbl[1].act[1] = 32'h02000000;
        tbl[1].wt[0]  = 32'h01000000; tbl[1].wt[1]  = 32'h00400000;
        tbl[1].bias = 32'h00000010; tbl[1].p_at = 999; tbl[1].directed = 1;
        tbl[1].exp_res = 32'h00900010; tbl[1].exp_done = 9;
        // zero length
        tbl[2].n = 0; tbl[2].p_at = 999; tbl[2].directed = 1;
        tbl[2].exp_res = 32'h0; tbl[2].exp_done = 1;
        // single pair, unpaused then paused 3 cycles after the first read
        tbl[3].n = 1; tbl[3].ab = 16'h0400; tbl[3].wb = 16'h0500; tbl[3].ba = 16'h0600;
        tbl[3].act[0] = 32'h01000000; tbl[3].wt[0] = 32'h00800000;
        tbl[3].bias = 32'h00100000; tbl[3].p_at = 999; tbl[3].directed = 1;
        tbl[3].exp_res = 32'h00900000; tbl[3].exp_done = 7;
        tbl[4] = tbl[3]; tbl[4].p_at = 2; tbl[4].p_len = 3; tbl[4].exp_done = 10;

        #22;
        cur_c = 0;
        chk("rst_mem_rd", 32'(mem_rd), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_acc_valid", 32'(acc_valid), 0);
        chk("rst_acc_data", acc_data, 0);
        chk("rst_acc_length", acc_length, 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_result", result, 0);
        reset = 1;

        prev_chain = 0;
        for (int i = 0; i < 5; i++) begin
            run_job(tbl[i], prev_chain);
            prev_chain = tbl[i].chain;
        end

        for (int t = 0; t < 10; t++) begin
            rj = '0;
            rj.n = $urandom_range(1, 6);
            rj.ab = 16'($urandom); rj.wb = 16'($urandom); rj.ba = 16'($urandom);
            for (int i = 0; i < 8; i++) begin
                rj.act[i] = $urandom; rj.wt[i] = $urandom;
            end
            rj.bias = $urandom;
            rj.rnd_pause = 1;
            rj.spam = 1'($urandom_range(0, 1));
            rj.chain = (t != 9) && ($urandom_range(0, 1) == 1);
            run_job(rj, prev_chain);
            prev_chain = rj.chain;
        end

        // mid-job reset
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            mem[16'h0700 + 16'(i)] = 32'h01000000;
            mem[16'h0800 + 16'(i)] = 32'h01000000;
        end
        length = 4; act_base = 16'h0700; wt_base = 16'h0800; bias_addr = 16'h0900;
        start = 1;
        repeat (5) begin
            @(posedge clk); #1;
            start = 0;
        end
        #1; cur_c = 5;
        chk("pre_rst_busy", 32'(busy), 1);
        chk("pre_rst_mem_rd", 32'(mem_rd), 1);
        reset = 0;
        #1;
        chk("midrst_mem_rd", 32'(mem_rd), 0);
        chk("midrst_mem_addr", 32'(mem_addr), 0);
        chk("midrst_acc_valid", 32'(acc_valid), 0);
        chk("midrst_acc_data", acc_data, 0);
        chk("midrst_acc_length", acc_length, 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_done", 32'(done), 0);
        chk("midrst_result", result, 0);
        @(posedge clk); #3;
        reset = 1;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #2; cur_c = c;
            chk("postrst_acc_valid", 32'(acc_valid), 0);
            chk("postrst_mem_rd", 32'(mem_rd), 0);
        end
        rj = tbl[0]; rj.spam = 0; rj.chain = 0;
        run_job(rj, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dense_feeder.md
DENSE_FEEDER -- requirements
Module: dense_feeder

Interface
REQ-001 The block SHALL use reset reset, asynchronous, active-low, and clock clk.
REQ-002 The block SHALL have these ports, in this order:
- clk  in  1  clock
- reset  in  1  async active-low reset
- start  in  1  begin one dense-neuron job; sampled only in IDLE
- length  in  32  number of activation/weight pairs N
- act_base  in  16  word address of activation 0
- wt_base  in  16  word address of weight 0
- bias_addr  in  16  word address of bias
- pause  in  1  blocks new memory reads while high
- mem_rd  out  1  memory read strobe
- mem_addr  out  16  memory word address
- mem_rdata  in  32  read data, valid exactly 1 cycle after mem_rd
- acc_valid  out  1  beat valid to denseAccelerator dataValid
- acc_data  out  32  beat data to denseAccelerator dataIn
- acc_length  out  32  latched N to denseAccelerator length
- acc_result  in  32  denseAccelerator dataOut
- busy  out  1  job in progress
- done  out  1  one-cycle completion pulse
- result  out  32  captured neuron sum

Function
REQ-003 States SHALL be IDLE, HDR, STREAM, WAIT, CAPTURE.
REQ-004 In IDLE with start=1 and length!=0, the block SHALL latch length/act_base/wt_base/bias_addr, assert busy and enter HDR next cycle; start in any other state SHALL be ignored.
REQ-005 In IDLE with start=1 and length==0, the block SHALL issue no reads or beats, SHALL pulse done the next cycle, and SHALL load result=0 in that same cycle.
REQ-006 In HDR, the block SHALL register one header beat (acc_valid=1, acc_data=N) for the following cycle, and SHALL then enter STREAM.
REQ-007 In STREAM, the block SHALL issue 2N+1 reads in order act[0], wt[0], act[1], wt[1], …, act[N-1], wt[N-1], bias, at most one per cycle.
REQ-008 Read addresses SHALL be act_base+i and wt_base+i, computed modulo 2^16 (wrap-around), and bias_addr for the final read.
REQ-009 The block SHALL NOT issue a read in any cycle in which pause=1; reads SHALL resume the cycle after pause falls.
REQ-010 Every read issued in cycle t SHALL produce exactly one beat in cycle t+2 (acc_valid=1, acc_data=mem_rdata registered at end of t+1).
REQ-011 Beats SHALL NOT be stalled or dropped; pause SHALL affect only read issue.
REQ-012 acc_valid SHALL be 0 in every cycle not defined as a beat cycle.
REQ-013 After the last read, the block SHALL enter WAIT until the bias beat has been driven.
REQ-014 If the bias beat is in cycle b, the block SHALL sample acc_result at the end of cycle b+1 into result.
REQ-015 In cycle b+2, done SHALL be 1 for one cycle, busy SHALL be 0, and the state SHALL be IDLE.
REQ-016 result SHALL hold its value until the next capture or reset.
REQ-017 A start asserted in the done cycle SHALL be accepted.
REQ-018 acc_length SHALL equal the latched N from job acceptance until the next job is accepted.
REQ-019 With no pause, total job latency from start acceptance to done SHALL be 2N+5 cycles.
REQ-020 Beat and read counters SHALL be 32 bits wide, and no count comparison SHALL overflow for N up to 2^31-1.

Reset
REQ-021 On reset low, the block SHALL immediately return to IDLE, including mid-job, with outputs mem_rd=0, mem_addr=0, acc_valid=0, acc_data=0, acc_length=0, busy=0, done=0, result=0, and all counters and pending-read pipeline bits cleared.
REQ-022 After reset release, the block SHALL issue no beat until a new start is accepted.

Verification
REQ-023 N=2, act={0x01000000,0x02000000}, wt={0x00800000,0x01000000}, bias=0x00100000, no pause, with denseAccelerator attached -> 6 consecutive acc_valid beats (0x2, act0, wt0, act1, wt1, bias), done 9 cycles after start accepted, result=0x02900000.
REQ-024 N=1, pause high for 3 cycles after the first read -> exactly a 3-cycle gap in acc_valid, beat order unchanged, result identical to the unpaused run.
REQ-025 length=0 -> mem_rd and acc_valid never asserted, done pulses the next cycle, result=0.
REQ-026 act_base=0xFFFF, wt_base=0x8000, N=2 -> read addresses 0xFFFF, 0x8000, 0x0000, 0x8001, bias_addr.
REQ-027 start re-asserted while busy -> ignored, with a single done pulse; start asserted in the done cycle -> second job runs back-to-back.
REQ-028 reset pulsed low mid-STREAM -> all outputs 0 immediately, and a subsequent job gives the same result as REQ-023.
